// File: rtl/din_conditioner.sv
// Digital-input conditioner: 2-FF synchroniser, tick-paced debounce and sticky edge flags per channel,
// with a coherent snapshot on snap. Optional glitch counter enabled by DIN_CONDITIONER_GLITCH_CNT_EN.
module din_conditioner #(
  parameter int             N      = 16,
  parameter int             DB_LIM = 4,
  parameter logic [N-1:0]   INIT   = '0
) (
  input  logic         clk,
  input  logic         nRESET,
  input  logic         tick,
  input  logic [N-1:0] din_raw,
  input  logic         snap,
  output logic [N-1:0] filt,
  output logic [N-1:0] snap_filt,
  output logic [N-1:0] snap_rise,
  output logic [N-1:0] snap_fall,
  output logic [7:0]   glitch_cnt
);

  if (DB_LIM < 1 || DB_LIM > 15) begin : g_bad_db_lim
    $error("din_conditioner: DB_LIM=%0d outside legal range 1..15", DB_LIM);
  end

  localparam logic [3:0] CNT_MAX = 4'(DB_LIM - 1);

  logic [N-1:0] s1_q, s2_q;
  logic [N-1:0] filt_q, filt_d;
  logic [3:0]   cnt_q [N];
  logic [3:0]   cnt_d [N];
  logic [N-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [N-1:0] rise_set, fall_set;
  logic [N-1:0] snap_filt_q, snap_filt_d;
  logic [N-1:0] snap_rise_q, snap_rise_d;
  logic [N-1:0] snap_fall_q, snap_fall_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latch).
    filt_d   = filt_q;
    rise_set = '0;
    fall_set = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (s2_q[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          filt_d[i]   = s2_q[i];
          cnt_d[i]    = '0;
          rise_set[i] = s2_q[i];
          fall_set[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end

    // Commits landing on the snap edge survive the clear and show in the next window.
    rise_d      = (snap ? '0 : rise_q) | rise_set;
    fall_d      = (snap ? '0 : fall_q) | fall_set;
    snap_filt_d = snap ? filt_q : snap_filt_q;
    snap_rise_d = snap ? rise_q : snap_rise_q;
    snap_fall_d = snap ? fall_q : snap_fall_q;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      s1_q        <= INIT;
      s2_q        <= INIT;
      filt_q      <= INIT;
      rise_q      <= '0;
      fall_q      <= '0;
      snap_filt_q <= INIT;
      snap_rise_q <= '0;
      snap_fall_q <= '0;
      // NOTE: the counter array is a bank of flops, not a RAM, so it is reset like any other state.
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      s1_q        <= din_raw;
      s2_q        <= s1_q;
      filt_q      <= filt_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      snap_filt_q <= snap_filt_d;
      snap_rise_q <= snap_rise_d;
      snap_fall_q <= snap_fall_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign filt      = filt_q;
  assign snap_filt = snap_filt_q;
  assign snap_rise = snap_rise_q;
  assign snap_fall = snap_fall_q;

`ifdef DIN_CONDITIONER_GLITCH_CNT_EN
  logic [N-1:0] abort;
  logic         any_abort;
  logic [7:0]   gl_q, gl_d;
  logic [7:0]   glitch_cnt_q, glitch_cnt_d;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      abort[i] = tick && (s2_q[i] == filt_q[i]) && (cnt_q[i] != 4'd0);
    end
    any_abort = |abort;

    // One increment per tick edge no matter how many channels abort; saturates at 255.
    gl_d = gl_q;
    if (snap) begin
      gl_d = {7'd0, any_abort};
    end else if (any_abort && gl_q != 8'hFF) begin
      gl_d = gl_q + 8'd1;
    end
    glitch_cnt_d = snap ? gl_q : glitch_cnt_q;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      gl_q         <= '0;
      glitch_cnt_q <= '0;
    end else begin
      gl_q         <= gl_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign glitch_cnt = glitch_cnt_q;
`else
  assign glitch_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_din_conditioner.sv
// Directed bench for din_conditioner: snapshot expectations are queued before each snap strobe
// and compared once the capture edge has passed.
module tb_din_conditioner;

  localparam int          N      = 16;
  localparam int          DB_LIM = 4;
  localparam logic [15:0] INIT   = 16'h00F0;

`ifdef DIN_CONDITIONER_GLITCH_CNT_EN
  localparam logic [7:0] GL_ONE = 8'd1;
  localparam logic [7:0] GL_SAT = 8'd255;
`else
  localparam logic [7:0] GL_ONE = 8'd0;
  localparam logic [7:0] GL_SAT = 8'd0;
`endif

  typedef struct {
    logic [15:0] f;
    logic [15:0] r;
    logic [15:0] fa;
    logic [7:0]  g;
  } snap_exp_t;

  logic          clk;
  logic          nRESET;
  logic          tick;
  logic [N-1:0]  din_raw;
  logic          snap;
  logic [N-1:0]  filt;
  logic [N-1:0]  snap_filt;
  logic [N-1:0]  snap_rise;
  logic [N-1:0]  snap_fall;
  logic [7:0]    glitch_cnt;

  snap_exp_t sb[$];
  int        n_checks = 0;
  int        n_fail   = 0;
  int        n_snap   = 0;
  int        tick_period = 1;
  int        tick_phase  = 0;

  din_conditioner #(.N(N), .DB_LIM(DB_LIM), .INIT(INIT)) dut (
    .clk        (clk),
    .nRESET     (nRESET),
    .tick       (tick),
    .din_raw    (din_raw),
    .snap       (snap),
    .filt       (filt),
    .snap_filt  (snap_filt),
    .snap_rise  (snap_rise),
    .snap_fall  (snap_fall),
    .glitch_cnt (glitch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n clk edges, pacing tick by tick_period; outputs are sampled 1ns after each edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick       = (tick_phase == 0);
      tick_phase = (tick_phase + 1 >= tick_period) ? 0 : tick_phase + 1;
      @(posedge clk);
      #1;
    end
    tick = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] f, input logic [15:0] r,
                          input logic [15:0] fa, input logic [7:0] g);
    snap_exp_t e;
    e.f = f; e.r = r; e.fa = fa; e.g = g;
    sb.push_back(e);
  endtask

  // Hold snap for n consecutive edges, comparing one queued snapshot after each.
  task automatic snap_pulses(input int n);
    snap_exp_t e;
    snap = 1'b1;
    for (int i = 0; i < n; i++) begin
      run(1);
      n_snap++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL snap%0d_queue: observed empty queue expected an entry", n_snap);
      end else begin
        e = sb.pop_front();
        check($sformatf("snap%0d_filt", n_snap), snap_filt, e.f);
        check($sformatf("snap%0d_rise", n_snap), snap_rise, e.r);
        check($sformatf("snap%0d_fall", n_snap), snap_fall, e.fa);
        check($sformatf("snap%0d_glitch", n_snap), {8'h00, glitch_cnt}, {8'h00, e.g});
      end
    end
    snap = 1'b0;
  endtask

  initial begin
    nRESET  = 1'b0;
    tick    = 1'b0;
    snap    = 1'b0;
    din_raw = 16'hFFFF;

    // Reset held: levels at INIT, flags and counts clear.
    repeat (3) @(posedge clk);
    #1;
    check("rst_filt", filt, INIT);
    check("rst_snap_filt", snap_filt, INIT);
    check("rst_snap_rise", snap_rise, 16'h0000);
    check("rst_snap_fall", snap_fall, 16'h0000);
    check("rst_glitch", {8'h00, glitch_cnt}, 16'h0000);

    // Release with tick high: new level lands on edge DB_LIM+2.
    nRESET      = 1'b1;
    tick_period = 1;
    tick_phase  = 0;
    run(DB_LIM + 1);
    check("rel_filt_before", filt, INIT);
    run(1);
    check("rel_filt_commit", filt, 16'hFFFF);
    run(2);
    push_exp(16'hFFFF, 16'hFF0F, 16'h0000, 8'd0);
    snap_pulses(1);

    din_raw = 16'h0000;
    run(10);
    check("all_low_filt", filt, 16'h0000);
    push_exp(16'h0000, 16'h0000, 16'hFFFF, 8'd0);
    snap_pulses(1);

    // Single rising channel: exactly 6 edges at DB_LIM=4.
    din_raw = 16'h0008;
    run(5);
    check("ch3_filt_edge5", filt, 16'h0000);
    run(1);
    check("ch3_filt_edge6", filt, 16'h0008);
    push_exp(16'h0008, 16'h0008, 16'h0000, 8'd0);
    snap_pulses(1);

    // Slow tick, channel 5 pulse for 3 ticks: aborted, no edge.
    tick_period = 64;
    tick_phase  = 0;
    din_raw     = 16'h0028;
    run(194);
    check("ch5_filt_pulse", filt, 16'h0008);
    din_raw = 16'h0008;
    run(128);
    check("ch5_filt_after", filt, 16'h0008);
    push_exp(16'h0008, 16'h0000, 16'h0000, GL_ONE);
    snap_pulses(1);

    // Commit on the same edge as snap: old level now, new level and flag next time.
    tick_period = 1;
    tick_phase  = 0;
    din_raw     = 16'h0009;
    run(5);
    check("ch0_filt_pre", filt, 16'h0008);
    push_exp(16'h0008, 16'h0000, 16'h0000, 8'd0);
    snap_pulses(1);
    check("ch0_filt_post", filt, 16'h0009);
    run(2);
    push_exp(16'h0009, 16'h0001, 16'h0000, 8'd0);
    snap_pulses(1);

    // Channel 7 up then down between snaps: both flags, then back-to-back snap clears.
    din_raw = 16'h0089;
    run(8);
    check("ch7_filt_high", filt, 16'h0089);
    din_raw = 16'h0009;
    run(8);
    check("ch7_filt_low", filt, 16'h0009);
    push_exp(16'h0009, 16'h0080, 16'h0080, 8'd0);
    push_exp(16'h0009, 16'h0000, 16'h0000, 8'd0);
    snap_pulses(2);

    // Channel 1 toggling every clk: an abort on every other tick, ~310 in total.
    for (int i = 0; i < 620; i++) begin
      din_raw[1] = ~din_raw[1];
      run(1);
    end
    din_raw = 16'h0009;
    run(6);
    check("ch1_filt_storm", filt, 16'h0009);
    push_exp(16'h0009, 16'h0000, 16'h0000, GL_SAT);
    snap_pulses(1);
    run(3);
    push_exp(16'h0009, 16'h0000, 16'h0000, 8'd0);
    snap_pulses(1);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
